// File: rtl/ysyx_22050039_idu_pipe.sv
// RV64I-subset decode stage with an integrated GPR file, writeback bypass and one output slot.
// An accepted ebreak or illegal instruction parks the stage in HALT until reset.
module ysyx_22050039_idu_pipe #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned INST_LEN = 32,
    parameter int unsigned NR_REG   = 32,
    parameter int unsigned REG_SEL  = 5,
    parameter int unsigned CNT_W    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INST_LEN-1:0] in_inst,
    input  logic [XLEN-1:0]     in_pc,
    input  logic                wb_en,
    input  logic [REG_SEL-1:0]  wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_src1,
    output logic [XLEN-1:0]     out_src2,
    output logic [XLEN-1:0]     out_sdata,
    output logic [REG_SEL-1:0]  out_rd,
    output logic                out_rd_wen,
    output logic [3:0]          out_func,
    output logic                out_pc_wen,
    output logic                out_illegal,
    output logic                halted,
    output logic [CNT_W-1:0]    inst_cnt
);

    localparam int unsigned IdxW = (NR_REG > 1) ? $clog2(NR_REG) : 1;

    localparam logic [3:0] FuncIll    = 4'd0;
    localparam logic [3:0] FuncAddi   = 4'd1;
    localparam logic [3:0] FuncJalr   = 4'd2;
    localparam logic [3:0] FuncAuipc  = 4'd3;
    localparam logic [3:0] FuncLui    = 4'd4;
    localparam logic [3:0] FuncSd     = 4'd5;
    localparam logic [3:0] FuncJal    = 4'd6;
    localparam logic [3:0] FuncEbreak = 4'd7;
    localparam logic [3:0] FuncAdd    = 4'd8;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     gpr_q [NR_REG];
    logic                accept;
    logic [CNT_W-1:0]    cnt_q;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [REG_SEL-1:0]  rs1, rs2, rd;
    logic [XLEN-1:0]     rs1_val, rs2_val;

    logic [3:0]          dec_func;
    logic [XLEN-1:0]     dec_src1, dec_src2, dec_sdata;
    logic                dec_rd_wen, dec_pc_wen, dec_illegal;

    logic                out_valid_q;
    logic [XLEN-1:0]     out_pc_q, out_src1_q, out_src2_q, out_sdata_q;
    logic [REG_SEL-1:0]  out_rd_q;
    logic                out_rd_wen_q, out_pc_wen_q, out_illegal_q;
    logic [3:0]          out_func_q;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rd     = REG_SEL'(in_inst[11:7]);
    assign rs1    = REG_SEL'(in_inst[19:15]);
    assign rs2    = REG_SEL'(in_inst[24:20]);

    // GPR file; indices beyond NR_REG are silently dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NR_REG); i++) gpr_q[i] <= '0;
        end else if (wb_en && wb_rd != '0 && 32'(wb_rd) < NR_REG) begin
            gpr_q[wb_rd[IdxW-1:0]] <= wb_data;
        end
    end

    // Operand read with same-cycle writeback bypass
    always_comb begin
        rs1_val = '0;
        if (rs1 != '0) begin
            if (wb_en && wb_rd == rs1)   rs1_val = wb_data;
            else if (32'(rs1) < NR_REG)  rs1_val = gpr_q[rs1[IdxW-1:0]];
        end
    end

    always_comb begin
        rs2_val = '0;
        if (rs2 != '0) begin
            if (wb_en && wb_rd == rs2)   rs2_val = wb_data;
            else if (32'(rs2) < NR_REG)  rs2_val = gpr_q[rs2[IdxW-1:0]];
        end
    end

    always_comb begin
        dec_func   = FuncIll;
        dec_src1   = '0;
        dec_src2   = '0;
        dec_sdata  = '0;
        dec_rd_wen = 1'b0;
        dec_pc_wen = 1'b0;
        case (opcode)
            7'b0010011: if (funct3 == 3'b000) begin
                dec_func   = FuncAddi;
                dec_src1   = rs1_val;
                dec_src2   = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
                dec_rd_wen = (rd != '0);
            end
            7'b0110011: if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                dec_func   = FuncAdd;
                dec_src1   = rs1_val;
                dec_src2   = rs2_val;
                dec_rd_wen = (rd != '0);
            end
            7'b1100111: if (funct3 == 3'b000) begin
                dec_func   = FuncJalr;
                dec_src1   = rs1_val;
                dec_src2   = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
                dec_rd_wen = (rd != '0);
                dec_pc_wen = 1'b1;
            end
            7'b0010111: begin
                dec_func   = FuncAuipc;
                dec_src1   = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
                dec_rd_wen = (rd != '0);
            end
            7'b0110111: begin
                dec_func   = FuncLui;
                dec_src1   = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
                dec_rd_wen = (rd != '0);
            end
            7'b0100011: if (funct3 == 3'b011) begin
                dec_func  = FuncSd;
                dec_src1  = rs1_val;
                dec_src2  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                dec_sdata = rs2_val;
            end
            7'b1101111: begin
                dec_func   = FuncJal;
                dec_src1   = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                              in_inst[20], in_inst[30:21], 1'b0};
                dec_rd_wen = (rd != '0);
                dec_pc_wen = 1'b1;
            end
            7'b1110011: if (in_inst[31:0] == 32'h0010_0073) dec_func = FuncEbreak;
            default: ;
        endcase
        dec_illegal = (dec_func == FuncIll);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StRun;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:  if (accept && (dec_illegal || dec_func == FuncEbreak)) state_d = StHalt;
            StHalt: state_d = StHalt;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        halted   = (state_q == StHalt);
        in_ready = (state_q == StRun) && (!out_valid_q || out_ready);
    end

    assign accept = in_valid && in_ready;

    // Payload is left as-is on drain; only out_valid drops
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_src1_q    <= '0;
            out_src2_q    <= '0;
            out_sdata_q   <= '0;
            out_rd_q      <= '0;
            out_rd_wen_q  <= 1'b0;
            out_func_q    <= FuncIll;
            out_pc_wen_q  <= 1'b0;
            out_illegal_q <= 1'b0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_pc_q      <= in_pc;
            out_src1_q    <= dec_src1;
            out_src2_q    <= dec_src2;
            out_sdata_q   <= dec_sdata;
            out_rd_q      <= rd;
            out_rd_wen_q  <= dec_rd_wen;
            out_func_q    <= dec_func;
            out_pc_wen_q  <= dec_pc_wen;
            out_illegal_q <= dec_illegal;
        end else if (out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         cnt_q <= '0;
        else if (accept) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_src1    = out_src1_q;
    assign out_src2    = out_src2_q;
    assign out_sdata   = out_sdata_q;
    assign out_rd      = out_rd_q;
    assign out_rd_wen  = out_rd_wen_q;
    assign out_func    = out_func_q;
    assign out_pc_wen  = out_pc_wen_q;
    assign out_illegal = out_illegal_q;
    assign inst_cnt    = cnt_q;

endmodule

// File: tb/tb_ysyx_22050039_idu_pipe.sv
// Bench for the decode stage: directed scenarios plus random traffic, all checked against a
// queue-based behavioural model of the stage.
module tb_ysyx_22050039_idu_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, wb_en, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc, wb_data, out_pc, out_src1, out_src2, out_sdata, inst_cnt;
    logic [4:0]  wb_rd, out_rd;
    logic        out_rd_wen, out_pc_wen, out_illegal, halted;
    logic [3:0]  out_func;

    always #5 clk = ~clk;

    ysyx_22050039_idu_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_src1(out_src1), .out_src2(out_src2), .out_sdata(out_sdata),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_func(out_func),
        .out_pc_wen(out_pc_wen), .out_illegal(out_illegal),
        .halted(halted), .inst_cnt(inst_cnt)
    );

    typedef struct {
        logic [3:0]  func;
        logic [63:0] pc, src1, src2, sdata;
        logic [4:0]  rd;
        logic        rd_wen, pc_wen, illegal;
    } bundle_t;

    bundle_t     exp_q[$];
    logic [63:0] m_gpr [32];
    bit          m_halt;
    logic [63:0] m_cnt;
    bit          m_acc;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] seen[$];
    logic [31:0] bp_insts [3] = '{32'h0010_0093, 32'h0020_0093, 32'h0030_0093};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        return 64'($signed(v << (64 - bits)) >>> (64 - bits));
    endfunction

    function automatic logic [63:0] m_read(input logic [4:0] idx, input bit we,
                                           input logic [4:0] wr, input logic [63:0] wd);
        if (idx == 0) return 64'd0;
        if (we && wr == idx) return wd;
        return m_gpr[idx];
    endfunction

    // Reference decode written from the ISA match/mask patterns
    function automatic bundle_t model_decode(input logic [31:0] inst, input logic [63:0] pc,
                                             input logic [63:0] r1, input logic [63:0] r2);
        bundle_t b;
        bit writes;
        logic [63:0] imm_i, imm_s, imm_u, imm_j;
        imm_i = sx(64'(inst[31:20]), 12);
        imm_s = sx(64'({inst[31:25], inst[11:7]}), 12);
        imm_u = sx(64'(inst & 32'hffff_f000), 32);
        imm_j = sx(64'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), 21);
        b = '{func: 4'd0, pc: pc, src1: 64'd0, src2: 64'd0, sdata: 64'd0,
              rd: inst[11:7], rd_wen: 1'b0, pc_wen: 1'b0, illegal: 1'b0};
        writes = 1'b1;
        if ((inst & 32'h707f) == 32'h13) begin
            b.func = 1; b.src1 = r1; b.src2 = imm_i;
        end else if ((inst & 32'hfe00_707f) == 32'h33) begin
            b.func = 8; b.src1 = r1; b.src2 = r2;
        end else if ((inst & 32'h707f) == 32'h67) begin
            b.func = 2; b.src1 = r1; b.src2 = imm_i; b.pc_wen = 1;
        end else if ((inst & 32'h7f) == 32'h17) begin
            b.func = 3; b.src1 = imm_u;
        end else if ((inst & 32'h7f) == 32'h37) begin
            b.func = 4; b.src1 = imm_u;
        end else if ((inst & 32'h707f) == 32'h3023) begin
            b.func = 5; b.src1 = r1; b.src2 = imm_s; b.sdata = r2; writes = 0;
        end else if ((inst & 32'h7f) == 32'h6f) begin
            b.func = 6; b.src1 = imm_j; b.pc_wen = 1;
        end else if (inst == 32'h0010_0073) begin
            b.func = 7; writes = 0;
        end else begin
            b.illegal = 1; writes = 0;
        end
        b.rd_wen = writes && (inst[11:7] != 0);
        return b;
    endfunction

    // One clock: drive at negedge, compare 1ns later, then advance the model past the posedge
    task automatic cycle(input bit r, input bit v, input logic [31:0] inst, input logic [63:0] pc,
                         input bit we, input logic [4:0] wr, input logic [63:0] wd,
                         input bit ordy);
        bit exp_rdy;
        bundle_t b;
        @(negedge clk);
        rst = r; in_valid = v; in_inst = inst; in_pc = pc;
        wb_en = we; wb_rd = wr; wb_data = wd; out_ready = ordy;
        #1;
        exp_rdy = !m_halt && (exp_q.size() == 0 || ordy);
        check("in_ready", in_ready, exp_rdy);
        check("halted", halted, m_halt);
        check("inst_cnt", inst_cnt, m_cnt);
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            b = exp_q[0];
            check("out_pc", out_pc, b.pc);
            check("out_func", out_func, b.func);
            check("out_src1", out_src1, b.src1);
            check("out_src2", out_src2, b.src2);
            check("out_sdata", out_sdata, b.sdata);
            check("out_rd", out_rd, b.rd);
            check("out_rd_wen", out_rd_wen, b.rd_wen);
            check("out_pc_wen", out_pc_wen, b.pc_wen);
            check("out_illegal", out_illegal, b.illegal);
        end
        m_acc = 0;
        if (r) begin
            exp_q.delete();
            foreach (m_gpr[i]) m_gpr[i] = 64'd0;
            m_halt = 0;
            m_cnt  = 64'd0;
            return;
        end
        m_acc = v && exp_rdy;
        if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
        if (m_acc) begin
            b = model_decode(inst, pc, m_read(inst[19:15], we, wr, wd),
                             m_read(inst[24:20], we, wr, wd));
            exp_q.push_back(b);
            m_cnt++;
            if (b.illegal || b.func == 4'd7) m_halt = 1;
        end
        if (we && wr != 0) m_gpr[wr] = wd;
    endtask

    task automatic idle(input bit ordy);
        cycle(0, 0, 32'd0, 64'd0, 0, 5'd0, 64'd0, ordy);
    endtask

    // Reset with acceptance and writeback requested in the same cycle; reset must win
    task automatic do_reset();
        cycle(1, 1, 32'h0010_0193, 64'h8000_0000, 1, 5'd3, 64'hdead_beef, 0);
        idle(0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_src1", out_src1, 0);
        check("rst_out_src2", out_src2, 0);
        check("rst_out_sdata", out_sdata, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_flags", {out_rd_wen, out_pc_wen, out_illegal, out_func}, 0);
        check("rst_halted", halted, 0);
        check("rst_inst_cnt", inst_cnt, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    function automatic logic [4:0] rnd_reg();
        if ($urandom_range(0, 1) != 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [31:0] rnd_inst();
        int unsigned k;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] i12;
        logic [19:0] i20;
        k = $urandom_range(0, 99);
        rd = rnd_reg(); rs1 = rnd_reg(); rs2 = rnd_reg();
        i12 = 12'($urandom); i20 = 20'($urandom);
        if (k < 30) return {i12, rs1, 3'b000, rd, 7'h13};
        if (k < 50) return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
        if (k < 58) return {i12, rs1, 3'b000, rd, 7'h67};
        if (k < 64) return {i20, rd, 7'h17};
        if (k < 70) return {i20, rd, 7'h37};
        if (k < 84) return {i12[11:5], rs2, rs1, 3'b011, i12[4:0], 7'h23};
        if (k < 96) return {i20, rd, 7'h6f};
        if (k == 96) return 32'h0010_0073;
        if (k == 97) return {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
        if (k == 98) return $urandom;
        return {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'h23};
    endfunction

    initial begin
        int k;
        rst = 1; in_valid = 0; in_inst = 0; in_pc = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        foreach (m_gpr[i]) m_gpr[i] = 64'd0;
        m_halt = 0; m_cnt = 0;
        do_reset();

        // addi x1,x0,5
        cycle(0, 1, 32'h0050_0093, 64'h100, 0, 5'd0, 64'd0, 1);
        idle(1);
        check("t1_valid", out_valid, 1);
        check("t1_func", out_func, 1);
        check("t1_src1", out_src1, 0);
        check("t1_src2", out_src2, 5);
        check("t1_rd", out_rd, 1);
        check("t1_rd_wen", out_rd_wen, 1);
        check("t1_cnt", inst_cnt, 1);

        // add x3,x2,x2 with x2 written in the same cycle
        cycle(0, 1, 32'h0021_01b3, 64'h104, 1, 5'd2, 64'h1234, 1);
        idle(1);
        check("t2_src1", out_src1, 64'h1234);
        check("t2_src2", out_src2, 64'h1234);
        cycle(0, 1, 32'h0001_0213, 64'h108, 0, 5'd0, 64'd0, 1);
        idle(1);
        check("t2_later_x2", out_src1, 64'h1234);

        // Backpressure: three instructions, out_ready low for the first four cycles
        seen.delete();
        k = 0;
        for (int c = 0; c < 16 && k < 3; c++) begin
            cycle(0, 1, bp_insts[k], 64'h200 + 64'(4 * k), 0, 5'd0, 64'd0, c >= 4);
            if (c >= 1 && c <= 3) check("t3_held_src2", out_src2, 1);
            if (out_valid && c >= 4) seen.push_back(out_src2);
            if (m_acc) k++;
        end
        check("t3_all_accepted", 64'(k), 3);
        idle(1);
        if (out_valid) seen.push_back(out_src2);
        check("t3_delivered", 64'(seen.size()), 3);
        for (int i = 0; i < seen.size() && i < 3; i++) check("t3_order", seen[i], 64'(i + 1));

        // jal x1,-4 and lui x5,0x80000
        cycle(0, 1, 32'hffdf_f0ef, 64'h300, 0, 5'd0, 64'd0, 1);
        idle(1);
        check("t4_jal_func", out_func, 6);
        check("t4_jal_src1", out_src1, 64'hffff_ffff_ffff_fffc);
        check("t4_jal_pc_wen", out_pc_wen, 1);
        cycle(0, 1, 32'h8000_02b7, 64'h304, 0, 5'd0, 64'd0, 1);
        idle(1);
        check("t4_lui_src1", out_src1, 64'hffff_ffff_8000_0000);

        // x0 stays zero; sd x0,8(x0); then an all-zero word halts the stage
        cycle(0, 0, 32'd0, 64'd0, 1, 5'd0, 64'hff, 1);
        cycle(0, 1, 32'h0000_3423, 64'h400, 0, 5'd0, 64'd0, 1);
        idle(1);
        check("t5_sd_src1", out_src1, 0);
        check("t5_sd_sdata", out_sdata, 0);
        check("t5_sd_src2", out_src2, 8);
        check("t5_sd_rd_wen", out_rd_wen, 0);
        cycle(0, 1, 32'h0000_0000, 64'h404, 0, 5'd0, 64'd0, 1);
        idle(1);
        check("t5_illegal", out_illegal, 1);
        check("t5_halted", halted, 1);
        do_reset();

        // ebreak halts; stage refuses input until reset
        cycle(0, 1, 32'h0010_0073, 64'h500, 0, 5'd0, 64'd0, 1);
        idle(1);
        check("t6_ebreak_func", out_func, 7);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 32'h0050_0093, 64'h504, 1, 5'(i + 1), 64'(i), 1);
            check("t6_in_ready", in_ready, 0);
        end
        do_reset();

        // Random traffic, several segments each starting from reset
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int n = 0; n < 250; n++) begin
                cycle($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, rnd_inst(),
                      {$urandom, $urandom}, $urandom_range(0, 1) != 0, rnd_reg(),
                      {$urandom, $urandom}, $urandom_range(0, 3) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
